// File: rtl/trans_pkg.sv
// Transaction layout shared between the assembler and the downstream validator.
package trans_pkg;
  localparam int TRANS_W         = 128;
  localparam int WORD_W          = 32;
  localparam int SENDER_MSB      = 127;
  localparam int SENDER_LSB      = 80;
  localparam int RECEIVER_MSB    = 79;
  localparam int RECEIVER_LSB    = 32;
  localparam int AMOUNT_MSB      = 31;
  localparam int AMOUNT_LSB      = 10;
  localparam int BIT_BLOCK_START = 9;
  localparam int RSVD_MSB        = 8;

  typedef struct packed {
    logic [SENDER_MSB-SENDER_LSB:0]     sender;
    logic [RECEIVER_MSB-RECEIVER_LSB:0] receiver;
    logic [AMOUNT_MSB-AMOUNT_LSB:0]     amount;
    logic                               block_start;
    logic [RSVD_MSB:0]                  rsvd;
  } trans_t;
endpackage

// File: rtl/trans_assembler_if.sv
// Link-side word ingress plus validator-side valid/ack presentation.
interface trans_assembler_if #(parameter int FIFO_DEPTH = 4);
  import trans_pkg::*;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic [WORD_W-1:0]  word_i;
  logic               word_valid_i;
  logic               word_ready_o;
  logic               block_start_i;
  logic [TRANS_W-1:0] data_o;
  logic               valid_o;
  logic               ack_i;
  logic [LVL_W-1:0]   level_o;
  logic [15:0]        trans_count_o;

  modport master (
    output word_i, word_valid_i, block_start_i, ack_i,
    input  word_ready_o, data_o, valid_o, level_o, trans_count_o
  );
  modport slave (
    input  word_i, word_valid_i, block_start_i, ack_i,
    output word_ready_o, data_o, valid_o, level_o, trans_count_o
  );
endinterface

// File: rtl/trans_fifo.sv
// Synchronous FIFO; head is read straight out of the storage registers.
module trans_fifo #(
  parameter int W     = 128,
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Power-of-2 depth lets the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/trans_assembler.sv
// Packs four 32-bit link words into a 128-bit transaction, buffers it, and
// presents one transaction at a time to the validator under valid/ack.
module trans_assembler
  import trans_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  trans_assembler_if.slave bus
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SHOW = 1'b1;

  logic [1:0]           idx;
  logic [3*WORD_W-1:0]  asm_q;
  logic                 bs_q;
  logic [WORD_W-1:0]    last_w;
  logic                 accept, push, pop, full, empty, ready;
  logic [TRANS_W-1:0]   head;
  logic [LVL_W-1:0]     level;
  logic [0:0]           state;
  logic [TRANS_W-1:0]   data_q;
  logic                 valid_q;
  logic [15:0]          cnt_q;
  trans_t               shown;

  // Word 3 is only refused when its push would overflow the FIFO.
  assign ready  = (idx != 2'd3) || !full;
  assign accept = bus.word_valid_i && ready;
  assign push   = accept && (idx == 2'd3);
  assign pop    = (state == IDLE) && !empty;
  assign shown  = trans_t'(data_q);

  always_comb begin
    last_w = bus.word_i;
    last_w[BIT_BLOCK_START] = bs_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx   <= '0;
      asm_q <= '0;
      bs_q  <= 1'b0;
    end else if (accept) begin
      idx <= idx + 1'b1;
      case (idx)
        2'd0: begin
          asm_q[3*WORD_W-1 -: WORD_W] <= bus.word_i;
          bs_q                        <= bus.block_start_i;
        end
        2'd1:    asm_q[2*WORD_W-1 -: WORD_W] <= bus.word_i;
        2'd2:    asm_q[WORD_W-1:0]           <= bus.word_i;
        default: ;
      endcase
    end
  end

  trans_fifo #(.W(TRANS_W), .DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({asm_q, last_w}),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state)
        IDLE: if (!empty) begin
          data_q  <= head;
          valid_q <= 1'b1;
          state   <= SHOW;
        end
        default: if (bus.ack_i) begin
          valid_q <= 1'b0;
          state   <= IDLE;
          if (shown.block_start)    cnt_q <= 16'd1;
          else if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
        end
      endcase
    end
  end

  assign bus.word_ready_o  = ready;
  assign bus.data_o        = data_q;
  assign bus.valid_o       = valid_q;
  assign bus.level_o       = level;
  assign bus.trans_count_o = cnt_q;
endmodule

// File: tb/tb_trans_assembler.sv
// Directed bench for trans_assembler: assembly, block tagging, backpressure,
// ack spacing and asynchronous reset.
module tb_trans_assembler;
  import trans_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  trans_assembler_if #(.FIFO_DEPTH(4)) bus();
  trans_assembler #(.FIFO_DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_cnt;

  function automatic logic [127:0] bp_t(input int i);
    logic [31:0] k;
    k = 32'(i);
    return {32'h1000_0000 + k, 32'h2000_0000 + k, 32'h3000_0000 + k, 32'h4000_0000 | (k << 12)};
  endfunction

  function automatic logic [127:0] pat_t(input logic [7:0] i);
    return {4{i, 24'h00C0DE}};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [31:0] w, input logic bs);
    int n = 0;
    bus.word_i = w; bus.block_start_i = bs; bus.word_valid_i = 1'b1;
    while (!bus.word_ready_o && n < 50) begin tick(); n++; end
    checks++;
    if (n >= 50) begin errors++; $display("FAIL ready_timeout got ready=%b want 1 within 50 cycles", bus.word_ready_o); end
    tick();
    bus.word_valid_i = 1'b0; bus.block_start_i = 1'b0;
  endtask

  task automatic send_trans(input logic [127:0] t, input logic bs);
    for (int k = 0; k < 4; k++) send_word(t[127-32*k -: 32], bs && (k == 0));
  endtask

  task automatic wait_valid(output bit ok);
    int n = 0;
    while (!bus.valid_o && n < 50) begin tick(); n++; end
    ok = bus.valid_o;
  endtask

  task automatic do_ack();
    bus.ack_i = 1'b1; tick(); bus.ack_i = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.valid_o, bus.level_o, bus.trans_count_o, bus.word_ready_o} !== {1'b0, 3'd0, 16'd0, 1'b1} || bus.data_o !== '0) begin
      errors++;
      $display("FAIL reset_state got v=%b lvl=%0d cnt=%0d rdy=%b data=%h want v=0 lvl=0 cnt=0 rdy=1 data=0",
               bus.valid_o, bus.level_o, bus.trans_count_o, bus.word_ready_o, bus.data_o);
    end
  endtask

  task automatic test_single();
    logic [127:0] exp = 128'h11112222_33334444_55556666_77770000;
    send_trans(128'h11112222_33334444_55556666_77770200, 1'b0);
    checks++;
    if (bus.valid_o !== 1'b0 || bus.level_o !== 3'd1) begin
      errors++; $display("FAIL single_push got v=%b lvl=%0d want v=0 lvl=1", bus.valid_o, bus.level_o);
    end
    tick();
    checks++;
    if (bus.valid_o !== 1'b1 || bus.data_o !== exp || bus.level_o !== 3'd0) begin
      errors++; $display("FAIL single_present got v=%b data=%h lvl=%0d want v=1 data=%h lvl=0", bus.valid_o, bus.data_o, bus.level_o, exp);
    end
    tick(); tick(); tick();
    checks++;
    if (bus.valid_o !== 1'b1 || bus.data_o !== exp) begin
      errors++; $display("FAIL single_hold got v=%b data=%h want v=1 data=%h", bus.valid_o, bus.data_o, exp);
    end
    do_ack();
    exp_cnt = 16'd1;
    checks++;
    if (bus.valid_o !== 1'b0 || bus.trans_count_o !== exp_cnt) begin
      errors++; $display("FAIL single_ack got v=%b cnt=%0d want v=0 cnt=%0d", bus.valid_o, bus.trans_count_o, exp_cnt);
    end
  endtask

  task automatic test_block_start();
    bit ok;
    logic [127:0] exp = 128'h11112222_33334444_55556666_77770200;
    send_trans(128'h11112222_33334444_55556666_77770000, 1'b1);
    wait_valid(ok);
    checks++;
    if (!ok || bus.data_o !== exp) begin
      errors++; $display("FAIL block_start_data got v=%b data=%h want v=1 data=%h", bus.valid_o, bus.data_o, exp);
    end
    do_ack();
    exp_cnt = 16'd1;
    checks++;
    if (bus.trans_count_o !== exp_cnt) begin
      errors++; $display("FAIL block_start_count got %0d want %0d", bus.trans_count_o, exp_cnt);
    end
    for (int i = 1; i <= 3; i++) begin
      send_trans(pat_t(8'(i)), 1'b0);
      wait_valid(ok);
      do_ack();
    end
    exp_cnt = 16'd4;
    checks++;
    if (bus.trans_count_o !== exp_cnt) begin
      errors++; $display("FAIL block_count_4 got %0d want %0d", bus.trans_count_o, exp_cnt);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [127:0] t5;
    bus.ack_i = 1'b0;
    for (int i = 0; i < 5; i++) send_trans(bp_t(i), 1'b0);
    checks++;
    if (bus.level_o !== 3'd4 || bus.valid_o !== 1'b1 || bus.data_o !== bp_t(0)) begin
      errors++; $display("FAIL bp_full got lvl=%0d v=%b data=%h want lvl=4 v=1 data=%h", bus.level_o, bus.valid_o, bus.data_o, bp_t(0));
    end
    t5 = bp_t(5);
    for (int k = 0; k < 3; k++) send_word(t5[127-32*k -: 32], 1'b0);
    checks++;
    if (bus.word_ready_o !== 1'b0) begin
      errors++; $display("FAIL bp_ready got %b want 0", bus.word_ready_o);
    end
    do_ack();
    send_word(t5[31:0], 1'b0);
    for (int i = 1; i <= 5; i++) begin
      wait_valid(ok);
      checks++;
      if (!ok || bus.data_o !== bp_t(i)) begin
        errors++; $display("FAIL bp_order[%0d] got v=%b data=%h want v=1 data=%h", i, bus.valid_o, bus.data_o, bp_t(i));
      end
      do_ack();
    end
    exp_cnt = exp_cnt + 16'd6;
    checks++;
    if (bus.trans_count_o !== exp_cnt || bus.level_o !== 3'd0) begin
      errors++; $display("FAIL bp_drain got cnt=%0d lvl=%0d want cnt=%0d lvl=0", bus.trans_count_o, bus.level_o, exp_cnt);
    end
  endtask

  task automatic test_ack_spacing();
    bit ok;
    logic [2:0] seq;
    logic [127:0] d;
    bus.ack_i = 1'b0;
    send_trans(pat_t(8'hA1), 1'b0);
    send_trans(pat_t(8'hB2), 1'b0);
    send_trans(pat_t(8'hC3), 1'b0);
    checks++;
    if (bus.level_o !== 3'd2 || bus.data_o !== pat_t(8'hA1)) begin
      errors++; $display("FAIL spacing_setup got lvl=%0d data=%h want lvl=2 data=%h", bus.level_o, bus.data_o, pat_t(8'hA1));
    end
    do_ack();
    tick();
    seq[2] = bus.valid_o;
    checks++;
    if (bus.data_o !== pat_t(8'hB2)) begin
      errors++; $display("FAIL spacing_b got %h want %h", bus.data_o, pat_t(8'hB2));
    end
    bus.ack_i = 1'b1; tick(); bus.ack_i = 1'b0;
    seq[1] = bus.valid_o;
    tick();
    seq[0] = bus.valid_o;
    checks++;
    if (seq !== 3'b101 || bus.data_o !== pat_t(8'hC3)) begin
      errors++; $display("FAIL spacing_seq got seq=%b data=%h want seq=101 data=%h", seq, bus.data_o, pat_t(8'hC3));
    end
    do_ack();
    exp_cnt = exp_cnt + 16'd3;
    d = pat_t(8'hD4);
    for (int k = 0; k < 3; k++) send_word(d[127-32*k -: 32], 1'b0);
    bus.ack_i = 1'b1;
    send_word(d[31:0], 1'b0);
    bus.ack_i = 1'b0;
    checks++;
    if (bus.valid_o !== 1'b0 || bus.level_o !== 3'd1 || bus.trans_count_o !== exp_cnt) begin
      errors++; $display("FAIL spurious_ack got v=%b lvl=%0d cnt=%0d want v=0 lvl=1 cnt=%0d", bus.valid_o, bus.level_o, bus.trans_count_o, exp_cnt);
    end
    wait_valid(ok);
    checks++;
    if (!ok || bus.data_o !== d) begin
      errors++; $display("FAIL spurious_data got v=%b data=%h want v=1 data=%h", bus.valid_o, bus.data_o, d);
    end
    do_ack();
    exp_cnt = exp_cnt + 16'd1;
    checks++;
    if (bus.trans_count_o !== exp_cnt) begin
      errors++; $display("FAIL spacing_count got %0d want %0d", bus.trans_count_o, exp_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [127:0] h = pat_t(8'h77);
    logic [127:0] j = 128'hCAFEF00D_0BADBEEF_12345678_9ABC0000;
    bus.ack_i = 1'b0;
    send_trans(pat_t(8'h01), 1'b0);
    send_trans(pat_t(8'h02), 1'b0);
    send_trans(pat_t(8'h03), 1'b0);
    for (int k = 0; k < 3; k++) send_word(h[127-32*k -: 32], 1'b1);
    checks++;
    if (bus.level_o !== 3'd2 || bus.valid_o !== 1'b1) begin
      errors++; $display("FAIL rst_setup got lvl=%0d v=%b want lvl=2 v=1", bus.level_o, bus.valid_o);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.valid_o, bus.level_o, bus.trans_count_o, bus.word_ready_o} !== {1'b0, 3'd0, 16'd0, 1'b1} || bus.data_o !== '0) begin
      errors++;
      $display("FAIL rst_mid got v=%b lvl=%0d cnt=%0d rdy=%b data=%h want v=0 lvl=0 cnt=0 rdy=1 data=0",
               bus.valid_o, bus.level_o, bus.trans_count_o, bus.word_ready_o, bus.data_o);
    end
    tick();
    rst = 1'b0;
    send_trans(j, 1'b0);
    wait_valid(ok);
    checks++;
    if (!ok || bus.data_o !== j || bus.level_o !== 3'd0) begin
      errors++; $display("FAIL rst_fresh got v=%b data=%h lvl=%0d want v=1 data=%h lvl=0", bus.valid_o, bus.data_o, bus.level_o, j);
    end
    do_ack();
  endtask

  initial begin
    rst = 1'b1;
    bus.word_i = '0; bus.word_valid_i = 1'b0; bus.block_start_i = 1'b0; bus.ack_i = 1'b0;
    exp_cnt = '0;
    tick(); tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_single();
    test_block_start();
    test_backpressure();
    test_ack_spacing();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
